switch_nport: RTL and testbench

SWITCH_NPORT -- requirements
Module: switch_nport

---
 rtl/switch_nport_pkg.sv | 27 ++
 rtl/switch_nport_fifo.sv | 57 +++++
 rtl/switch_nport.sv | 215 +++++++++++++++++++++
 tb/tb_switch_nport.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_nport_pkg.sv
// Shared types and constants for the N-port packet switch.
// SWITCH_NPORT_BCAST_EN enables the all-ones broadcast destination.
package switch_nport_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SA   = 2'd1;
  localparam state_t ST_LEN  = 2'd2;
  localparam state_t ST_PAY  = 2'd3;

  // DA, SA and LEN precede the payload
  localparam int unsigned HDR_WORDS = 3;

  localparam int unsigned REG_ADDR_BASE = 0;

  function automatic int unsigned reg_drop_base(input int unsigned num_ports);
    return num_ports;
  endfunction

`ifdef SWITCH_NPORT_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

endpackage

// File: rtl/switch_nport_fifo.sv
// Per-port word FIFO; reports empty and free space for packet admission.
module switch_nport_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != DEPTH_W);
  assign do_rd = rd_en_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (!do_wr && do_rd) begin
        count_q <= count_q - (AW + 1)'(1);
      end
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign free_o    = DEPTH_W - count_q;

endmodule

// File: rtl/switch_nport.sv
// N-port packet switch: DA-addressed store into per-port FIFOs, register-mapped config.
// Build option: SWITCH_NPORT_BCAST_EN makes DA all-ones address every port.
module switch_nport
  import switch_nport_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_LEN    = 61
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sw_enable_in,
  input  logic [WORD_WIDTH-1:0]           data_in,
  output logic                            sw_busy,
  input  logic [NUM_PORTS-1:0]            port_read,
  output logic [NUM_PORTS*WORD_WIDTH-1:0] port_out,
  output logic [NUM_PORTS-1:0]            port_valid,
  output logic [NUM_PORTS-1:0]            port_ready,
  input  logic                            mem_sel_en,
  input  logic                            mem_wr_rd_s,
  input  logic [WORD_WIDTH-1:0]           mem_addr,
  input  logic [WORD_WIDTH-1:0]           mem_wr_data,
  output logic [WORD_WIDTH-1:0]           mem_rd_data,
  output logic                            mem_ack
);

  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] ADMIT_SPACE = FW'(MAX_LEN + HDR_WORDS);
  localparam logic [WORD_WIDTH-1:0] MAX_LEN_W = WORD_WIDTH'(MAX_LEN);

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   len_q, len_d;
  logic [WORD_WIDTH-1:0]   pay_cnt_q, pay_cnt_d;
  logic [NUM_PORTS-1:0]    accept_q, accept_d;
  logic [NUM_PORTS-1:0]    match, admit, drop_inc, wr_en, pop;
  logic                    wr_eop;
  logic [WORD_WIDTH-1:0]   wr_word, len_clip, stored_len;

  logic [NUM_PORTS-1:0][WORD_WIDTH:0]   fifo_rd_data;
  logic [NUM_PORTS-1:0]                 fifo_empty;
  logic [NUM_PORTS-1:0][FW-1:0]         fifo_free;
  logic [NUM_PORTS-1:0][FW-1:0]         pkt_cnt_q;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0] port_out_q;
  logic [NUM_PORTS-1:0]                 port_valid_q;

  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0] addr_q, drop_q;
  logic                                 mem_ack_q, reg_wr;
  logic [WORD_WIDTH-1:0]                mem_rd_q, rd_val;

  assign len_clip   = (data_in > MAX_LEN_W) ? MAX_LEN_W : data_in;
  assign stored_len = (len_q > MAX_LEN_W) ? MAX_LEN_W : len_q;

  // A port admits only if a maximum-size packet is guaranteed to fit.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      match[i] = (data_in == addr_q[i]) || (BCAST_EN && (data_in == '1));
      admit[i] = match[i] && (fifo_free[i] >= ADMIT_SPACE);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pay_cnt_d = pay_cnt_q;
    accept_d  = accept_q;
    wr_en     = '0;
    wr_eop    = 1'b0;
    wr_word   = data_in;
    drop_inc  = '0;
    if (sw_enable_in) begin
      case (state_q)
        ST_IDLE: begin
          accept_d = admit;
          wr_en    = admit;
          drop_inc = match & ~admit;
          state_d  = ST_SA;
        end
        ST_SA: begin
          wr_en   = accept_q;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          wr_en     = accept_q;
          wr_word   = len_clip;
          len_d     = data_in;
          pay_cnt_d = '0;
          if (data_in == '0) begin
            wr_eop  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAY;
          end
        end
        ST_PAY: begin
          // words past MAX_LEN are consumed but not stored
          if (pay_cnt_q < MAX_LEN_W) begin
            wr_en = accept_q;
          end
          wr_eop    = (pay_cnt_q == stored_len - WORD_WIDTH'(1));
          pay_cnt_d = pay_cnt_q + WORD_WIDTH'(1);
          if (pay_cnt_q == len_q - WORD_WIDTH'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      pay_cnt_q <= '0;
      accept_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pay_cnt_q <= pay_cnt_d;
      accept_q  <= accept_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    switch_nport_fifo #(
      .WIDTH(WORD_WIDTH + 1),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_en_i  (wr_en[g]),
      .wr_data_i({wr_eop, wr_word}),
      .rd_en_i  (pop[g]),
      .rd_data_o(fifo_rd_data[g]),
      .empty_o  (fifo_empty[g]),
      .free_o   (fifo_free[g])
    );
  end

  assign pop = port_read & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q    <= '0;
      port_out_q   <= '0;
      port_valid_q <= '0;
    end else begin
      port_valid_q <= pop;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (pop[i]) begin
          port_out_q[i] <= fifo_rd_data[i][WORD_WIDTH-1:0];
        end
        if ((wr_en[i] && wr_eop) && !(pop[i] && fifo_rd_data[i][WORD_WIDTH])) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + FW'(1);
        end else if (!(wr_en[i] && wr_eop) && (pop[i] && fifo_rd_data[i][WORD_WIDTH])) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] - FW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_ready[i] = (pkt_cnt_q[i] != '0);
    end
  end

  assign port_out   = port_out_q;
  assign port_valid = port_valid_q;
  assign sw_busy    = (state_q != ST_IDLE);

  assign reg_wr = mem_sel_en && mem_wr_rd_s;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (mem_addr == WORD_WIDTH'(REG_ADDR_BASE + i)) begin
        rd_val = addr_q[i];
      end
      if (mem_addr == WORD_WIDTH'(reg_drop_base(NUM_PORTS) + i)) begin
        rd_val = drop_q[i];
      end
    end
  end

  // A clearing write wins over a same-cycle drop increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        addr_q[i] <= WORD_WIDTH'(i);
      end
      drop_q    <= '0;
      mem_ack_q <= 1'b0;
      mem_rd_q  <= '0;
    end else begin
      mem_ack_q <= mem_sel_en;
      mem_rd_q  <= (mem_sel_en && !mem_wr_rd_s) ? rd_val : '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (reg_wr && (mem_addr == WORD_WIDTH'(REG_ADDR_BASE + i))) begin
          addr_q[i] <= mem_wr_data;
        end
        if (reg_wr && (mem_addr == WORD_WIDTH'(reg_drop_base(NUM_PORTS) + i))) begin
          drop_q[i] <= '0;
        end else if (drop_inc[i] && (drop_q[i] != '1)) begin
          drop_q[i] <= drop_q[i] + WORD_WIDTH'(1);
        end
      end
    end
  end

  assign mem_ack     = mem_ack_q;
  assign mem_rd_data = mem_rd_q;

endmodule

// File: tb/tb_switch_nport.sv
// Self-checking bench for switch_nport: register table, directed packet cases, random traffic.
module tb_switch_nport;

  localparam int NP    = 4;
  localparam int WW    = 8;
  localparam int DEPTH = 64;
  localparam int MAXL  = 61;

`ifdef SWITCH_NPORT_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sw_enable_in;
  logic [WW-1:0]    data_in;
  logic             sw_busy;
  logic [NP-1:0]    port_read, port_valid, port_ready;
  logic [NP*WW-1:0] port_out;
  logic             mem_sel_en, mem_wr_rd_s;
  logic [WW-1:0]    mem_addr, mem_wr_data, mem_rd_data;
  logic             mem_ack;

  switch_nport #(
    .NUM_PORTS (NP),
    .WORD_WIDTH(WW),
    .FIFO_DEPTH(DEPTH),
    .MAX_LEN   (MAXL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_enable_in(sw_enable_in),
    .data_in     (data_in),
    .sw_busy     (sw_busy),
    .port_read   (port_read),
    .port_out    (port_out),
    .port_valid  (port_valid),
    .port_ready  (port_ready),
    .mem_sel_en  (mem_sel_en),
    .mem_wr_rd_s (mem_wr_rd_s),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: expected contents of each port as {eop, word}
  logic [8:0]    mq [NP][$];
  logic [7:0]    m_addr [NP];
  logic [7:0]    m_drop [NP];
  logic [7:0]    m_out  [NP];
  logic [NP-1:0] m_valid;
  int            pk, plen, slen;
  logic [NP-1:0] pacc;
  logic [7:0]    payload[$];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      m_addr[p] = 8'(p);
      m_drop[p] = 8'h00;
      m_out[p]  = 8'h00;
    end
    m_valid = '0;
    pk      = 0;
    pacc    = '0;
  endtask

  function automatic logic [NP-1:0] exp_ready();
    logic [NP-1:0] r;
    logic [8:0]    e;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < mq[p].size(); k++) begin
        e = mq[p][k];
        if (e[8]) r[p] = 1'b1;
      end
    end
    return r;
  endfunction

  // Interprets one consumed input word according to the packet format.
  task automatic model_word(input logic [7:0] w, output logic [NP-1:0] push, output logic [8:0] word);
    bit m;
    int j;
    case (pk)
      0: begin
        for (int p = 0; p < NP; p++) begin
          m = (m_addr[p] == w) || (BCAST && (w == 8'hFF));
          pacc[p] = 1'b0;
          if (m) begin
            if (DEPTH - mq[p].size() >= MAXL + 3) pacc[p] = 1'b1;
            else if (m_drop[p] != 8'hFF) m_drop[p] = m_drop[p] + 8'd1;
          end
        end
        push = pacc; word = {1'b0, w}; pk = 1;
      end
      1: begin
        push = pacc; word = {1'b0, w}; pk = 2;
      end
      2: begin
        plen = int'(w);
        slen = (plen > MAXL) ? MAXL : plen;
        push = pacc; word = {(plen == 0), 8'(slen)};
        pk = (plen == 0) ? 0 : 3;
      end
      default: begin
        j = pk - 3;
        push = (j < MAXL) ? pacc : '0;
        word = {(j == slen - 1), w};
        pk = (j == plen - 1) ? 0 : pk + 1;
      end
    endcase
  endtask

  task automatic cycle(input bit en, input logic [7:0] w, input logic [NP-1:0] rd);
    logic [NP-1:0]    push;
    logic [8:0]       word, tmp;
    logic [NP*WW-1:0] ev;
    sw_enable_in = en;
    data_in      = w;
    port_read    = rd;
    push = '0;
    word = '0;
    if (en) model_word(w, push, word);
    for (int p = 0; p < NP; p++) begin
      m_valid[p] = 1'b0;
      if (rd[p] && mq[p].size() > 0) begin
        tmp = mq[p].pop_front();
        m_out[p]   = tmp[7:0];
        m_valid[p] = 1'b1;
      end
    end
    for (int p = 0; p < NP; p++) if (push[p]) mq[p].push_back(word);
    @(negedge clk);
    for (int p = 0; p < NP; p++) ev[p*WW +: WW] = m_out[p];
    check("port_valid", port_valid, m_valid);
    check("port_out", port_out, ev);
    check("port_ready", port_ready, exp_ready());
    check("sw_busy", sw_busy, pk != 0);
    sw_enable_in = 1'b0;
    port_read    = '0;
  endtask

  task automatic fill_payload(input int len);
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
  endtask

  task automatic send_packet(input logic [7:0] da, input logic [7:0] sa, input int len,
                             input int stall_pct, input int rd_pct);
    logic [7:0]    words[$];
    logic [NP-1:0] rd;
    bit            en;
    int            idx;
    words.delete();
    words.push_back(da);
    words.push_back(sa);
    words.push_back(8'(len));
    for (int i = 0; i < len; i++) words.push_back(payload[i]);
    idx = 0;
    while (idx < words.size()) begin
      en = ($urandom_range(0, 99) >= stall_pct);
      for (int p = 0; p < NP; p++) rd[p] = ($urandom_range(0, 99) < rd_pct);
      cycle(en, en ? words[idx] : 8'($urandom), rd);
      if (en) idx++;
    end
  endtask

  task automatic drain(input int p);
    int guard;
    guard = 0;
    while (mq[p].size() > 0 && guard < 200) begin
      cycle(1'b0, 8'h00, NP'(1) << p);
      guard++;
    end
    cycle(1'b0, 8'h00, NP'(1) << p);
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
    mem_sel_en = 1'b1; mem_wr_rd_s = 1'b1; mem_addr = addr; mem_wr_data = data;
    @(negedge clk);
    mem_sel_en = 1'b0; mem_wr_rd_s = 1'b0;
    check("wr_ack", mem_ack, 1'b1);
    check("wr_rd_data", mem_rd_data, 8'h00);
    if (int'(addr) < NP) m_addr[addr] = data;
    else if (int'(addr) < 2 * NP) m_drop[int'(addr) - NP] = 8'h00;
  endtask

  task automatic reg_read(input logic [7:0] addr, input logic [7:0] exp);
    mem_sel_en = 1'b1; mem_wr_rd_s = 1'b0; mem_addr = addr;
    @(negedge clk);
    mem_sel_en = 1'b0;
    check("rd_ack", mem_ack, 1'b1);
    check("rd_data", mem_rd_data, exp);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e35[5];
    logic [7:0] dsel[6];
    int         cnt, len;

    rst = 1'b1; sw_enable_in = 1'b0; data_in = '0; port_read = '0;
    mem_sel_en = 1'b0; mem_wr_rd_s = 1'b0; mem_addr = '0; mem_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", sw_busy, 1'b0);
    check("rst_valid", port_valid, '0);
    check("rst_ready", port_ready, '0);
    check("rst_out", port_out, '0);
    check("rst_ack", mem_ack, 1'b0);
    check("rst_rd_data", mem_rd_data, '0);
    rst = 1'b0;
    model_reset();

    // register map after reset
    tbl = '{
      '{1'b0, 8'd0,   8'h00, 8'd0},
      '{1'b0, 8'd1,   8'h00, 8'd1},
      '{1'b0, 8'd2,   8'h00, 8'd2},
      '{1'b0, 8'd3,   8'h00, 8'd3},
      '{1'b0, 8'd4,   8'h00, 8'd0},
      '{1'b0, 8'd7,   8'h00, 8'd0},
      '{1'b0, 8'd8,   8'h00, 8'd0},
      '{1'b0, 8'hFF,  8'h00, 8'd0},
      '{1'b1, 8'd8,   8'h05, 8'd0},
      '{1'b0, 8'd8,   8'h00, 8'd0},
      '{1'b1, 8'd3,   8'h33, 8'd0},
      '{1'b0, 8'd3,   8'h00, 8'h33},
      '{1'b1, 8'd3,   8'h03, 8'd0}
    };
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].wdata);
      else reg_read(tbl[i].addr, tbl[i].exp);
    end
    @(negedge clk);
    check("ack_idle", mem_ack, 1'b0);

    // basic routing to port 1
    payload.delete(); payload.push_back(8'hA0); payload.push_back(8'hA1);
    send_packet(8'd1, 8'd9, 2, 0, 0);
    check("req035_ready", port_ready, 4'b0010);
    e35 = '{8'h01, 8'h09, 8'h02, 8'hA0, 8'hA1};
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 8'h00, 4'b0010);
      check("req035_word", port_out[15:8], e35[k]);
    end
    check("req035_ready_after", port_ready, 4'b0000);
    cycle(1'b0, 8'h00, 4'b0010);

    // port 2 aliased to address 1
    reg_write(8'd2, 8'd1);
    fill_payload(3);
    send_packet(8'd1, 8'd4, 3, 30, 0);
    check("req036_ready", port_ready, 4'b0110);
    drain(1);
    drain(2);
    reg_write(8'd2, 8'd2);

    // insufficient space drops the second packet
    fill_payload(1);
    send_packet(8'd0, 8'd7, 1, 0, 0);
    fill_payload(2);
    send_packet(8'd0, 8'd7, 2, 0, 0);
    check("req037_ready", port_ready, 4'b0001);
    reg_read(8'd4, 8'd1);
    reg_write(8'd4, 8'h55);
    reg_read(8'd4, 8'd0);

    // drop increment coincides with a clearing write
    mem_sel_en = 1'b1; mem_wr_rd_s = 1'b1; mem_addr = 8'd4; mem_wr_data = 8'h00;
    cycle(1'b1, 8'd0, 4'b0000);
    mem_sel_en = 1'b0; mem_wr_rd_s = 1'b0;
    m_drop[0] = 8'h00;
    cycle(1'b1, 8'd2, 4'b0000);
    cycle(1'b1, 8'd0, 4'b0000);
    reg_read(8'd4, 8'd0);
    drain(0);

    // oversize packet truncated, following packet still routed
    fill_payload(70);
    send_packet(8'd3, 8'd5, 70, 10, 0);
    check("req038_ready", port_ready, 4'b1000);
    cnt = 0;
    while (mq[3].size() > 0 && cnt < 100) begin
      cycle(1'b0, 8'h00, 4'b1000);
      cnt++;
      if (cnt == 3) check("req038_len", port_out[31:24], 8'd61);
    end
    check("req038_words", cnt, 64);
    cycle(1'b0, 8'h00, 4'b1000);
    fill_payload(3);
    send_packet(8'd2, 8'd6, 3, 0, 0);
    check("req038_next", port_ready, 4'b0100);
    drain(2);

    // broadcast destination
    fill_payload(2);
    send_packet(8'hFF, 8'd1, 2, 0, 0);
    check("bcast_ready", port_ready, BCAST ? 4'b1111 : 4'b0000);
    for (int p = 0; p < NP; p++) drain(p);

    // write and pop on the same port in the same cycles
    fill_payload(6);
    send_packet(8'd2, 8'd4, 6, 0, 100);
    drain(2);

    // reset in mid-payload
    fill_payload(1);
    send_packet(8'd0, 8'd3, 1, 0, 0);
    cycle(1'b1, 8'd1, '0);
    cycle(1'b1, 8'd3, '0);
    cycle(1'b1, 8'd5, '0);
    cycle(1'b1, 8'h11, '0);
    cycle(1'b1, 8'h22, '0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", sw_busy, 1'b0);
    check("mid_rst_valid", port_valid, '0);
    check("mid_rst_ready", port_ready, '0);
    check("mid_rst_out", port_out, '0);
    check("mid_rst_ack", mem_ack, 1'b0);
    check("mid_rst_rd_data", mem_rd_data, '0);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 8'h00, 4'b0011);
    fill_payload(5);
    send_packet(8'd1, 8'd3, 5, 20, 0);
    check("post_rst_ready", port_ready, 4'b0010);
    drain(1);

    // random traffic against the model
    dsel = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'hFF};
    for (int n = 0; n < 40; n++) begin
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(0, 6));
      fill_payload(len);
      send_packet(dsel[$urandom_range(0, 5)], 8'($urandom), len, 20, 15);
      if ($urandom_range(0, 3) == 0) for (int p = 0; p < NP; p++) drain(p);
      if (n % 5 == 4) begin
        for (int p = 0; p < NP; p++) reg_read(8'(NP + p), m_drop[p]);
      end
      if ($urandom_range(0, 9) == 0) reg_write(8'(NP + $urandom_range(0, NP - 1)), 8'h00);
    end
    for (int p = 0; p < NP; p++) drain(p);
    for (int p = 0; p < NP; p++) reg_read(8'(NP + p), m_drop[p]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
